// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Registered, parametrised ALU with valid/ready handshakes on both
//            sides. Single-cycle ops return in one cycle; MUL/DIV/MOD run
//            one shift-add / restoring-subtract step per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH     = 8,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       choice,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
    localparam logic [CW-1:0]    C_CNT_INIT = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_INC  = 5'h02;
    localparam logic [4:0] OP_DEC  = 5'h03;
    localparam logic [4:0] OP_AND  = 5'h04;
    localparam logic [4:0] OP_OR   = 5'h05;
    localparam logic [4:0] OP_XOR  = 5'h06;
    localparam logic [4:0] OP_NOT  = 5'h07;
    localparam logic [4:0] OP_SHL  = 5'h08;
    localparam logic [4:0] OP_SHR  = 5'h09;
    localparam logic [4:0] OP_ASR  = 5'h0A;
    localparam logic [4:0] OP_ROL  = 5'h0B;
    localparam logic [4:0] OP_ROR  = 5'h0C;
    localparam logic [4:0] OP_CMP  = 5'h0D;
    localparam logic [4:0] OP_PASS = 5'h0E;
    localparam logic [4:0] OP_MUL  = 5'h0F;
    localparam logic [4:0] OP_DIV  = 5'h10;
    localparam logic [4:0] OP_MOD  = 5'h11;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [0:0]       state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [4:0]       op_q,        op_d;
    logic [WIDTH-1:0] opnd_q,      opnd_d;   // multiplicand (MUL) or divisor (DIV/MOD)
    logic [WIDTH-1:0] hi_q,        hi_d;     // product high half / partial remainder
    logic [WIDTH-1:0] lo_q,        lo_d;     // multiplier / dividend, becomes low product / quotient
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             carry_q,     carry_d;
    logic             borrow_q,    borrow_d;
    logic             zero_q,      zero_d;
    logic             neg_q,       neg_d;
    logic             ovf_q,       ovf_d;
    logic             ill_q,       ill_d;

    // ------------------------------------------------------------------------
    // Request decode and handshake
    // ------------------------------------------------------------------------
    logic w_accept;
    logic w_is_md;
    logic w_illegal;

    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_is_md   = MULDIV_EN &&
                       ((choice == OP_MUL) || (choice == OP_DIV) || (choice == OP_MOD));
    assign w_illegal = (choice > OP_PASS) && !w_is_md;

    // ------------------------------------------------------------------------
    // Single-cycle arithmetic: one adder for ADD/INC, one subtractor for
    // SUB/DEC/CMP, with the constant one muxed in for INC/DEC.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_add_rhs;
    logic [WIDTH-1:0] w_sub_rhs;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;

    assign w_add_rhs = (choice == OP_INC) ? C_ONE : B;
    assign w_sub_rhs = (choice == OP_DEC) ? C_ONE : B;
    assign w_sum     = {1'b0, A} + {1'b0, w_add_rhs};
    assign w_diff    = {1'b0, A} - {1'b0, w_sub_rhs};
    assign w_add_ovf = (A[MSB] == w_add_rhs[MSB]) && (w_sum[MSB]  != A[MSB]);
    assign w_sub_ovf = (A[MSB] != w_sub_rhs[MSB]) && (w_diff[MSB] != A[MSB]);

    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_b;
    logic             w_alu_v;

    // Single-cycle result and op-specific flags (zero/negative come later from the final result)
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_b   = 1'b0;
        w_alu_v   = 1'b0;
        case (choice)
            OP_ADD, OP_INC: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = w_add_ovf;
            end
            OP_SUB, OP_DEC: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_alu_b   = w_diff[WIDTH];
                w_alu_v   = w_sub_ovf;
            end
            OP_CMP: begin
                w_alu_res = A;
                w_alu_b   = w_diff[WIDTH];
                w_alu_v   = w_sub_ovf;
            end
            OP_AND:  w_alu_res = A & B;
            OP_OR:   w_alu_res = A | B;
            OP_XOR:  w_alu_res = A ^ B;
            OP_NOT:  w_alu_res = ~A;
            OP_SHL: begin
                w_alu_res = {A[MSB-1:0], 1'b0};
                w_alu_c   = A[MSB];
            end
            OP_SHR: begin
                w_alu_res = {1'b0, A[MSB:1]};
                w_alu_c   = A[0];
            end
            OP_ASR: begin
                w_alu_res = {A[MSB], A[MSB:1]};
                w_alu_c   = A[0];
            end
            OP_ROL: begin
                w_alu_res = {A[MSB-1:0], A[MSB]};
                w_alu_c   = A[MSB];
            end
            OP_ROR: begin
                w_alu_res = {A[0], A[MSB:1]};
                w_alu_c   = A[0];
            end
            OP_PASS: w_alu_res = B;
            default: w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Iterative step datapath
    // ------------------------------------------------------------------------
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_trial;
    logic             w_div_zero;
    logic             w_qbit;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

    // Shift-add: conditionally add the multiplicand into the high half, then
    // shift the whole {carry, hi, lo} right by one.
    assign w_mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], lo_q[MSB:1]};

    // Restoring divide: bring in the next dividend bit and try to subtract the
    // divisor. With a zero divisor every trial is forced to succeed, so the
    // quotient fills with ones and the remainder ends up equal to A.
    assign w_div_zero = (opnd_q == '0);
    assign w_trial    = {hi_q, lo_q[MSB]} - {1'b0, opnd_q};
    assign w_qbit     = w_div_zero || !w_trial[WIDTH];
    assign w_div_hi   = w_qbit ? w_trial[WIDTH-1:0] : {hi_q[MSB-1:0], lo_q[MSB]};
    assign w_div_lo   = {lo_q[MSB-1:0], w_qbit};

    // ------------------------------------------------------------------------
    // Next-state, datapath and output-register logic
    // ------------------------------------------------------------------------
    logic             w_ld_en;
    logic [WIDTH-1:0] w_ld_res;
    logic             w_ld_c;
    logic             w_ld_b;
    logic             w_ld_v;
    logic             w_ld_ill;

    // Sequencer: accept requests, run the iterative steps, load the output register
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        opnd_d      = opnd_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_valid_d = out_valid_q && !out_ready;
        w_ld_en     = 1'b0;
        w_ld_res    = '0;
        w_ld_c      = 1'b0;
        w_ld_b      = 1'b0;
        w_ld_v      = 1'b0;
        w_ld_ill    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_md) begin
                        op_d    = choice;
                        opnd_d  = (choice == OP_MUL) ? A : B;
                        lo_d    = (choice == OP_MUL) ? B : A;
                        hi_d    = '0;
                        cnt_d   = C_CNT_INIT;
                        state_d = S_CALC;
                    end else begin
                        w_ld_en  = 1'b1;
                        w_ld_res = w_illegal ? '0 : w_alu_res;
                        w_ld_c   = !w_illegal && w_alu_c;
                        w_ld_b   = !w_illegal && w_alu_b;
                        w_ld_v   = !w_illegal && w_alu_v;
                        w_ld_ill = w_illegal;
                    end
                end
            end
            S_CALC: begin
                if (op_q == OP_MUL) begin
                    hi_d = w_mul_hi;
                    lo_d = w_mul_lo;
                end else begin
                    hi_d = w_div_hi;
                    lo_d = w_div_lo;
                end
                if (cnt_q == '0) begin
                    w_ld_en = 1'b1;
                    state_d = S_IDLE;
                    if (op_q == OP_MUL) begin
                        w_ld_res = w_mul_lo;
                        w_ld_v   = (w_mul_hi != '0);
                    end else begin
                        w_ld_res = (op_q == OP_DIV) ? w_div_lo : w_div_hi;
                        w_ld_v   = w_div_zero;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        result_d = result_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        if (w_ld_en) begin
            out_valid_d = 1'b1;
            result_d    = w_ld_res;
            carry_d     = w_ld_c;
            borrow_d    = w_ld_b;
            ovf_d       = w_ld_v;
            ill_d       = w_ld_ill;
            zero_d      = !w_ld_ill && (w_ld_res == '0);
            neg_d       = !w_ld_ill && w_ld_res[MSB];
        end
    end

    // All state flops; an in-flight operation is dropped on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            opnd_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            opnd_q      <= opnd_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            borrow_q    <= borrow_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            ill_q       <= ill_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign zero       = zero_q;
    assign negative   = neg_q;
    assign overflow   = ovf_q;
    assign illegal    = ill_q;

endmodule
`default_nettype wire
